// File: rtl/gpio_pattern_seq.sv
// gpio_pattern_seq: plays a stored list of (value, hold) steps onto a WIDTH-bit bus.
// Each step is held for max(hold,1) cycles, and the whole list is repeated repeat_cnt extra times.
// Optional build macro PATTERN_SEQ_LOOP_EN adds the loop port. When loop is sampled high at start,
// the pattern replays until abort or reset.
module gpio_pattern_seq #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 16,
    parameter int unsigned      HOLD_W    = 16,
    parameter int unsigned      REP_W     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int unsigned     AW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WIDTH-1:0]  wr_value,
    input  logic [HOLD_W-1:0] wr_hold,
    input  logic [AW-1:0]     last_idx,
    input  logic [REP_W-1:0]  repeat_cnt,
    input  logic              start,
    input  logic              abort,
`ifdef PATTERN_SEQ_LOOP_EN
    input  logic              loop,
`endif
    output logic [WIDTH-1:0]  gpio_out,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     step_idx
);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    logic [WIDTH-1:0]  r_mem_value [DEPTH];
    logic [HOLD_W-1:0] r_mem_hold  [DEPTH];

    state_t            r_state, w_state_d;
    logic [WIDTH-1:0]  r_gpio, w_gpio_d;
    logic [AW-1:0]     r_step, w_step_d;
    logic [AW-1:0]     r_last, w_last_d;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_d;
    logic [REP_W-1:0]  r_pass, w_pass_d;
    logic              r_busy, r_done, w_done_d;

    logic              w_idle;
    logic              w_start_ok;
    logic              w_fwd;
    logic              w_loop_act;
    logic [AW-1:0]     w_nxt_idx;
    logic [AW-1:0]     w_rd_addr;
    logic [WIDTH-1:0]  w_rd_value;
    logic [HOLD_W-1:0] w_rd_hold;
    logic [HOLD_W-1:0] w_hold_load;

    assign w_idle     = (r_state == S_IDLE);
    assign w_start_ok = w_idle && start && !abort;

    // Pattern memory: written only while idle, never reset
    always_ff @(posedge clk) begin
        if (wr_en && w_idle) begin
            r_mem_value[wr_addr] <= wr_value;
            r_mem_hold[wr_addr]  <= wr_hold;
        end
    end

`ifdef PATTERN_SEQ_LOOP_EN
    logic r_loop;

    // Latch the loop request together with the other start-time controls
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_loop <= 1'b0;
        end else if (w_start_ok) begin
            r_loop <= loop;
        end
    end

    assign w_loop_act = r_loop;
`else
    assign w_loop_act = 1'b0;
`endif

    // Read port. A write to entry 0 in the start cycle is forwarded so the first step uses the new data.
    assign w_nxt_idx   = (r_step == r_last) ? '0 : r_step + AW'(1);
    assign w_rd_addr   = w_idle ? '0 : w_nxt_idx;
    assign w_fwd       = w_idle && wr_en && (wr_addr == '0);
    assign w_rd_value  = w_fwd ? wr_value : r_mem_value[w_rd_addr];
    assign w_rd_hold   = w_fwd ? wr_hold  : r_mem_hold[w_rd_addr];
    assign w_hold_load = (w_rd_hold == '0) ? '0 : w_rd_hold - HOLD_W'(1);

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_gpio     <= RESET_VAL;
            r_step     <= '0;
            r_last     <= '0;
            r_hold_cnt <= '0;
            r_pass     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_gpio     <= w_gpio_d;
            r_step     <= w_step_d;
            r_last     <= w_last_d;
            r_hold_cnt <= w_hold_d;
            r_pass     <= w_pass_d;
            r_busy     <= (w_state_d == S_RUN);
            r_done     <= w_done_d;
        end
    end

    // Next-state logic: step sequencing, pass counting, abort and completion
    always_comb begin
        w_state_d = r_state;
        w_gpio_d  = r_gpio;
        w_step_d  = r_step;
        w_last_d  = r_last;
        w_hold_d  = r_hold_cnt;
        w_pass_d  = r_pass;
        w_done_d  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_d = S_RUN;
                    w_gpio_d  = w_rd_value;
                    w_step_d  = '0;
                    w_hold_d  = w_hold_load;
                    w_last_d  = last_idx;
                    w_pass_d  = repeat_cnt;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_d = S_IDLE;
                end else if (r_hold_cnt != '0) begin
                    w_hold_d = r_hold_cnt - HOLD_W'(1);
                end else if (r_step != r_last) begin
                    w_step_d = w_nxt_idx;
                    w_gpio_d = w_rd_value;
                    w_hold_d = w_hold_load;
                end else if (w_loop_act || (r_pass != '0)) begin
                    w_step_d = '0;
                    w_gpio_d = w_rd_value;
                    w_hold_d = w_hold_load;
                    if (!w_loop_act) begin
                        w_pass_d = r_pass - REP_W'(1);
                    end
                end else begin
                    w_state_d = S_IDLE;
                    w_done_d  = 1'b1;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    assign gpio_out = r_gpio;
    assign busy     = r_busy;
    assign done     = r_done;
    assign step_idx = r_step;

endmodule

// File: tb/tb_gpio_pattern_seq.sv
// Testbench for gpio_pattern_seq. It checks the design against an expected-trace model built from step lists.
module tb_gpio_pattern_seq;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned HOLD_W = 16;
    localparam int unsigned REP_W  = 8;
    localparam int unsigned AW     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [WIDTH-1:0]  wr_value;
    logic [HOLD_W-1:0] wr_hold;
    logic [AW-1:0]     last_idx;
    logic [REP_W-1:0]  repeat_cnt;
    logic              start;
    logic              abort;
`ifdef PATTERN_SEQ_LOOP_EN
    logic              loop;
`endif
    logic [WIDTH-1:0]  gpio_out;
    logic              busy;
    logic              done;
    logic [AW-1:0]     step_idx;

    always #5 clk = ~clk;

    gpio_pattern_seq dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_value   (wr_value),
        .wr_hold    (wr_hold),
        .last_idx   (last_idx),
        .repeat_cnt (repeat_cnt),
        .start      (start),
        .abort      (abort),
`ifdef PATTERN_SEQ_LOOP_EN
        .loop       (loop),
`endif
        .gpio_out   (gpio_out),
        .busy       (busy),
        .done       (done),
        .step_idx   (step_idx)
    );

    int checks = 0;
    int passed = 0;

    // Reference memory and the expected per-cycle trace while busy
    logic [WIDTH-1:0] mdl_val  [DEPTH];
    int               mdl_hold [DEPTH];
    logic [WIDTH-1:0] exp_q[$];
    int               exp_step_q[$];

    // Observed trace
    logic [WIDTH-1:0] seen_q[$];
    int               seen_step_q[$];
    int               done_busy;
    logic             done_end;
    logic             done_after;
    logic [WIDTH-1:0] gpio_end;
    logic             timed_out;

    // Expected output: every pass plays steps 0..last, and each step lasts max(hold,1) cycles
    function automatic void build_exp(input int last, input int rep);
        exp_q.delete();
        exp_step_q.delete();
        for (int p = 0; p <= rep; p++)
            for (int s = 0; s <= last; s++)
                for (int c = 0; c < ((mdl_hold[s] > 0) ? mdl_hold[s] : 1); c++) begin
                    exp_q.push_back(mdl_val[s]);
                    exp_step_q.push_back(s);
                end
    endfunction

    // All driving tasks start and end on a falling edge
    task automatic wr(input int a, input logic [WIDTH-1:0] v, input int h);
        wr_en = 1'b1; wr_addr = AW'(a); wr_value = v; wr_hold = HOLD_W'(h);
        @(negedge clk);
        wr_en = 1'b0;
        mdl_val[a]  = v;
        mdl_hold[a] = h;
    endtask

    task automatic go(input int last, input int rep);
        last_idx = AW'(last); repeat_cnt = REP_W'(rep); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic collect(input int max_cycles);
        int n;
        n = 0;
        seen_q.delete();
        seen_step_q.delete();
        done_busy = 0;
        timed_out = 1'b0;
        while (busy === 1'b1 && n < max_cycles) begin
            seen_q.push_back(gpio_out);
            seen_step_q.push_back(int'(step_idx));
            if (done === 1'b1) done_busy++;
            @(negedge clk);
            n++;
        end
        if (n >= max_cycles) timed_out = 1'b1;
        done_end = done;
        gpio_end = gpio_out;
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (gpio_out !== 8'h00) $display("FAIL reset_gpio got %h exp 00", gpio_out); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else passed++;
        checks++; if (step_idx !== 4'd0) $display("FAIL reset_step got %0d exp 0", step_idx); else passed++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_toggle();
        int bad;
        wr(0, 8'h00, 2000);
        wr(1, 8'h01, 2000);
        go(1, 4);
        collect(25000);
        build_exp(1, 4);
        bad = 0;
        foreach (exp_q[i]) if (i >= seen_q.size() || seen_q[i] !== exp_q[i]) bad++;
        checks++; if (timed_out || seen_q.size() != 20000) $display("FAIL toggle_busy_cycles got %0d exp 20000", seen_q.size()); else passed++;
        checks++; if (bad != 0) $display("FAIL toggle_trace bad_cycles %0d exp 0", bad); else passed++;
        checks++; if (done_end !== 1'b1 || done_after !== 1'b0 || done_busy != 0) $display("FAIL toggle_done got end=%b after=%b during=%0d exp 1 0 0", done_end, done_after, done_busy); else passed++;
        checks++; if (gpio_end !== 8'h01) $display("FAIL toggle_final got %h exp 01", gpio_end); else passed++;
    endtask

    task automatic test_hold_zero();
        int bad;
        wr(0, 8'hA5, 0);
        wr(1, 8'h5A, 1);
        go(1, 0);
        collect(100);
        build_exp(1, 0);
        bad = (seen_q.size() == exp_q.size()) ? 0 : 1;
        foreach (exp_q[i]) if (i >= seen_q.size() || seen_q[i] !== exp_q[i] || seen_step_q[i] != exp_step_q[i]) bad++;
        checks++; if (bad != 0) $display("FAIL hold_zero_trace got %0d cycles exp 2 (bad %0d)", seen_q.size(), bad); else passed++;
        checks++; if (done_end !== 1'b1 || done_after !== 1'b0) $display("FAIL hold_zero_done got end=%b after=%b exp 1 0", done_end, done_after); else passed++;
    endtask

    task automatic test_abort();
        wr(0, 8'h11, 4); wr(1, 8'h22, 4); wr(2, 8'h33, 4); wr(3, 8'h44, 4);
        go(3, 0);
        repeat (13) @(negedge clk);
        checks++; if (step_idx !== 4'd3 || gpio_out !== 8'h44) $display("FAIL abort_pre got step %0d gpio %h exp 3 44", step_idx, gpio_out); else passed++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_idle got busy %b done %b exp 0 0", busy, done); else passed++;
        checks++; if (gpio_out !== 8'h44) $display("FAIL abort_frozen got %h exp 44", gpio_out); else passed++;
        @(negedge clk);
        checks++; if (done !== 1'b0 || gpio_out !== 8'h44) $display("FAIL abort_after got done %b gpio %h exp 0 44", done, gpio_out); else passed++;
        wr(0, 8'h99, 1);
        go(0, 0);
        collect(100);
        checks++; if (seen_q.size() != 1 || seen_q[0] !== 8'h99) $display("FAIL abort_then_write got %0d cycles first %h exp 1 99", seen_q.size(), (seen_q.size() > 0) ? seen_q[0] : 8'hxx); else passed++;
    endtask

    task automatic test_contention();
        int bad;
        abort = 1'b1; start = 1'b1; last_idx = '0; repeat_cnt = '0;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL start_abort_busy got %b exp 0", busy); else passed++;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL start_abort_idle got busy %b done %b exp 0 0", busy, done); else passed++;
        wr(0, 8'h10, 3);
        wr(1, 8'h20, 3);
        go(1, 1);
        // Write and restart attempt while busy; both must be ignored
        wr_en = 1'b1; wr_addr = '0; wr_value = 8'hEE; wr_hold = HOLD_W'(7); start = 1'b1;
        last_idx = 4'd9; repeat_cnt = 8'd9;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        collect(100);
        build_exp(1, 1);
        void'(exp_q.pop_front());
        bad = (seen_q.size() == exp_q.size()) ? 0 : 1;
        foreach (exp_q[i]) if (i >= seen_q.size() || seen_q[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) $display("FAIL busy_ignore_trace got %0d cycles exp %0d (bad %0d)", seen_q.size(), exp_q.size(), bad); else passed++;
        go(1, 1);
        collect(100);
        build_exp(1, 1);
        bad = (seen_q.size() == exp_q.size()) ? 0 : 1;
        foreach (exp_q[i]) if (i >= seen_q.size() || seen_q[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) $display("FAIL busy_write_replay got %0d cycles exp %0d (bad %0d)", seen_q.size(), exp_q.size(), bad); else passed++;
    endtask

    task automatic test_write_with_start();
        int bad;
        wr_en = 1'b1; wr_addr = '0; wr_value = 8'h77; wr_hold = HOLD_W'(2);
        go(0, 1);
        wr_en = 1'b0;
        mdl_val[0] = 8'h77; mdl_hold[0] = 2;
        collect(100);
        build_exp(0, 1);
        bad = (seen_q.size() == exp_q.size()) ? 0 : 1;
        foreach (exp_q[i]) if (i >= seen_q.size() || seen_q[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) $display("FAIL write_start_trace got %0d cycles first %h exp 4 77", seen_q.size(), (seen_q.size() > 0) ? seen_q[0] : 8'hxx); else passed++;
    endtask

    task automatic test_random();
        int bad, last, rep;
        for (int it = 0; it < 4; it++) begin
            for (int a = 0; a < 16; a++) wr(a, WIDTH'($urandom), int'($urandom_range(0, 4)));
            last = int'($urandom_range(0, 15));
            rep  = int'($urandom_range(0, 3));
            go(last, rep);
            collect(2000);
            build_exp(last, rep);
            bad = (seen_q.size() == exp_q.size()) ? 0 : 1;
            foreach (exp_q[i]) if (i >= seen_q.size() || seen_q[i] !== exp_q[i] || seen_step_q[i] != exp_step_q[i]) bad++;
            checks++; if (bad != 0 || timed_out) $display("FAIL random_trace it %0d got %0d cycles exp %0d (bad %0d)", it, seen_q.size(), exp_q.size(), bad); else passed++;
            checks++; if (done_end !== 1'b1 || gpio_end !== mdl_val[last]) $display("FAIL random_end it %0d got done %b gpio %h exp 1 %h", it, done_end, gpio_end, mdl_val[last]); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        wr(0, 8'h3F, 5);
        wr(1, 8'hF3, 5);
        go(1, 2);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || gpio_out !== 8'h00 || step_idx !== 4'd0) $display("FAIL reset_mid got busy %b done %b gpio %h step %0d exp 0 0 00 0", busy, done, gpio_out, step_idx); else passed++;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_mid_after got busy %b done %b exp 0 0", busy, done); else passed++;
    endtask

`ifdef PATTERN_SEQ_LOOP_EN
    task automatic test_loop();
        int bad, dn;
        logic [WIDTH-1:0] e;
        wr(0, 8'h3C, 3);
        wr(1, 8'hC3, 3);
        loop = 1'b1;
        go(1, int'($urandom_range(0, 3)));
        loop = 1'b0;
        bad = 0; dn = 0;
        for (int c = 0; c < 1000; c++) begin
            e = ((c % 6) < 3) ? 8'h3C : 8'hC3;
            if (busy !== 1'b1 || gpio_out !== e) bad++;
            if (done !== 1'b0) dn++;
            @(negedge clk);
        end
        checks++; if (bad != 0) $display("FAIL loop_period bad_cycles %0d exp 0", bad); else passed++;
        checks++; if (dn != 0) $display("FAIL loop_done pulses %0d exp 0", dn); else passed++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL loop_abort got busy %b done %b exp 0 0", busy, done); else passed++;
    endtask
`endif

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_value = '0; wr_hold = '0;
        last_idx = '0; repeat_cnt = '0; start = 1'b0; abort = 1'b0;
`ifdef PATTERN_SEQ_LOOP_EN
        loop = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_hold_zero();
        test_abort();
        test_contention();
        test_write_with_start();
        test_random();
        test_reset_mid();
        test_toggle();
`ifdef PATTERN_SEQ_LOOP_EN
        test_loop();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
